lamp_conflict_monitor: RTL

- Sits directly downstream of the traffic-light sequencer, between its four 3-bit light outputs and the lamp drivers.
- Checks every clock for illegal encodings and conflicting right-of-way, and debounces violations over a configurable number of cycles.
- On a confirmed fault, overrides the lamps with a flashing safe pattern until an operator clears it. A clear is followed by an all-red recovery interval.

---
 rtl/lamp_conflict_monitor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lamp_conflict_monitor.sv
// Lamp conflict monitor: screens the sequencer's light outputs for illegal encodings
// and conflicting right-of-way, and overrides the lamps with a flashing safe pattern on a confirmed fault.
module lamp_conflict_monitor #(
   parameter int CONFIRM_CYCLES = 2,
   parameter int FLASH_TICKS    = 1,
   parameter int RECOVER_TICKS  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       fault_clear,
   input  logic [2:0] in_M1,
   input  logic [2:0] in_M2,
   input  logic [2:0] in_MT,
   input  logic [2:0] in_S,
   output logic [2:0] lamp_M1,
   output logic [2:0] lamp_M2,
   output logic [2:0] lamp_MT,
   output logic [2:0] lamp_S,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [7:0] fault_count
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLASH   = 2'd1,
      RECOVER = 2'd2
   } state_t;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   localparam logic [3:0] CONFIRM_MAX  = 4'(CONFIRM_CYCLES);
   localparam logic [3:0] CONFIRM_LAST = 4'(CONFIRM_CYCLES - 1);
   localparam logic [3:0] FLASH_LAST   = 4'(FLASH_TICKS - 1);
   localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_TICKS - 1);

   // state is the FSM debug signal; bind checkers to it directly
   state_t     state;
   logic [3:0] confirm_cnt;
   logic [3:0] tick_cnt;
   logic       flash_on;
   logic [1:0] viol_code;
   logic       viol;
   logic       confirmed;
   logic       enter_flash;

   function automatic logic is_onehot(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   function automatic logic is_open(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010);
   endfunction

   always_comb begin
      viol_code = 2'd0;
      if (!(is_onehot(in_M1) && is_onehot(in_M2) && is_onehot(in_MT) && is_onehot(in_S)))
         viol_code = 2'd1;
      else if (is_open(in_S) && (is_open(in_M1) || is_open(in_M2) || is_open(in_MT)))
         viol_code = 2'd2;
      else if (is_open(in_MT) && is_open(in_M2))
         viol_code = 2'd3;
   end

   assign viol        = (viol_code != 2'd0);
   assign confirmed   = viol && (confirm_cnt == CONFIRM_LAST);
   assign enter_flash = confirmed && ((state == RUN) || (state == RECOVER));

   // Debounce runs in every state so a fresh violation in RECOVER starts from zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         confirm_cnt <= 4'd0;
      else if (!viol)
         confirm_cnt <= 4'd0;
      else if (confirm_cnt != CONFIRM_MAX)
         confirm_cnt <= confirm_cnt + 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         tick_cnt    <= 4'd0;
         flash_on    <= 1'b0;
         lamp_M1     <= LAMP_RED;
         lamp_M2     <= LAMP_RED;
         lamp_MT     <= LAMP_RED;
         lamp_S      <= LAMP_RED;
         fault       <= 1'b0;
         fault_code  <= 2'd0;
         fault_count <= 8'd0;
      end else if (enter_flash) begin
         // A same-edge tick is dropped: the tick counter restarts at zero
         state      <= FLASH;
         tick_cnt   <= 4'd0;
         flash_on   <= 1'b1;
         lamp_M1    <= LAMP_YEL;
         lamp_M2    <= LAMP_YEL;
         lamp_MT    <= LAMP_YEL;
         lamp_S     <= LAMP_RED;
         fault      <= 1'b1;
         fault_code <= viol_code;
         if (fault_count != 8'hFF)
            fault_count <= fault_count + 8'd1;
      end else begin
         case (state)
            RUN: begin
               if (!viol) begin
                  lamp_M1 <= in_M1;
                  lamp_M2 <= in_M2;
                  lamp_MT <= in_MT;
                  lamp_S  <= in_S;
               end
            end
            FLASH: begin
               if (fault_clear && !viol) begin
                  state    <= RECOVER;
                  tick_cnt <= 4'd0;
                  lamp_M1  <= LAMP_RED;
                  lamp_M2  <= LAMP_RED;
                  lamp_MT  <= LAMP_RED;
                  lamp_S   <= LAMP_RED;
               end else if (tick) begin
                  if (tick_cnt == FLASH_LAST) begin
                     tick_cnt <= 4'd0;
                     flash_on <= !flash_on;
                     lamp_M1  <= flash_on ? LAMP_OFF : LAMP_YEL;
                     lamp_M2  <= flash_on ? LAMP_OFF : LAMP_YEL;
                     lamp_MT  <= flash_on ? LAMP_OFF : LAMP_YEL;
                     lamp_S   <= flash_on ? LAMP_OFF : LAMP_RED;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            RECOVER: begin
               if (tick) begin
                  if (tick_cnt == RECOVER_LAST) begin
                     state      <= RUN;
                     tick_cnt   <= 4'd0;
                     fault      <= 1'b0;
                     fault_code <= 2'd0;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            default: begin
               state      <= RUN;
               tick_cnt   <= 4'd0;
               flash_on   <= 1'b0;
               lamp_M1    <= LAMP_RED;
               lamp_M2    <= LAMP_RED;
               lamp_MT    <= LAMP_RED;
               lamp_S     <= LAMP_RED;
               fault      <= 1'b0;
               fault_code <= 2'd0;
            end
         endcase
      end
   end

endmodule
